// File: rtl/gb_pkg.sv
// Shared definitions for the gb fetch path and gbprocessor.
package gb_pkg;
  localparam int WIDTH_DEFAULT = 8;
  typedef logic [7:0] gb_byte_t;
endpackage

// File: rtl/gb_fetch_fifo.sv
// Small circular buffer for opcode bytes: storage, pointers, explicit count,
// push/pop/flush and full/empty flags. Callers gate push/pop appropriately.
module gb_fetch_fifo
  import gb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  // a flush cancels anything else happening in the same cycle
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];

  // storage needs no reset: entries are only read once counted as valid
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // pointers wrap naturally (power-of-two depth); count tracked explicitly
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/gb_fetch_queue.sv
// Fetch queue feeding gbprocessor: FIFO plus a registered output stage that
// advances whenever it is empty or the processor is not stalling.
module gb_fetch_queue
  import gb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       stall,
  output logic [WIDTH-1:0]           instruction,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  logic [WIDTH-1:0] head;
  logic             full, empty;
  logic             push, pop, load;

  // no pass-through when full: a same-cycle pop does not open a slot
  assign in_ready = reset && !full && !flush;
  assign push     = in_valid && in_ready;
  assign load     = !valid || !stall;
  assign pop      = load && !empty && !flush;

  gb_fetch_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .flush (flush),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // output stage: load head when free, drop valid when nothing to show
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid       <= 1'b0;
      instruction <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      if (!empty) begin
        instruction <= head;
        valid       <= 1'b1;
      end else begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gb_fetch_queue.sv
// Self-checking bench for gb_fetch_queue: directed scenarios plus a random
// stall/in_valid run compared against a queue-based reference model.
module tb_gb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             flush = 1'b0;
  logic             stall = 1'b0;
  logic [WIDTH-1:0] instruction;
  logic             valid;
  logic [CW-1:0]    count;

  int errors = 0;
  int checks = 0;

  // reference model: bytes waiting, plus the presented output
  logic [7:0] mq[$];
  logic       mvalid = 1'b0;
  logic [7:0] minstr = 8'h00;
  logic       mready;
  logic       rdy_seen;
  logic [7:0] acc[$];
  logic [7:0] dlog[$];

  gb_fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .stall       (stall),
    .instruction (instruction),
    .valid       (valid),
    .count       (count)
  );

  always #5 clock = ~clock;

  // one clock cycle: drive inputs, advance model, land 1 time unit past edge
  task automatic drive(input logic v, input logic [7:0] d, input logic st, input logic fl);
    logic acc_now;
    in_valid = v; in_data = d; stall = st; flush = fl;
    #1;
    rdy_seen = in_ready;
    mready   = (mq.size() < DEPTH) && !fl;
    acc_now  = v && mready;
    if (valid && !st && !fl) dlog.push_back(instruction);
    @(posedge clock);
    if (fl) begin
      mq.delete();
      mvalid = 1'b0;
    end else begin
      if (!mvalid || !st) begin
        if (mq.size() > 0) begin
          minstr = mq.pop_front();
          mvalid = 1'b1;
        end else mvalid = 1'b0;
      end
      if (acc_now) begin
        mq.push_back(d);
        acc.push_back(d);
      end
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (instruction !== 8'h00) begin errors++; $display("FAIL reset_instr: got %h want 00", instruction); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] exp [3];
    exp[0] = 8'h3E; exp[1] = 8'h42; exp[2] = 8'h80;
    drive(1'b1, exp[0], 1'b0, 1'b0);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_latency: valid got %b want 0", valid); end
    for (int i = 0; i < 3; i++) begin
      drive(i < 2, (i < 2) ? exp[i+1] : 8'h00, 1'b0, 1'b0);
      checks++;
      if (valid !== 1'b1 || instruction !== exp[i]) begin
        errors++; $display("FAIL basic_out%0d: got v=%b %h want v=1 %h", i, valid, instruction, exp[i]);
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (valid !== 1'b0 || instruction !== 8'h80) begin
      errors++; $display("FAIL basic_tail: got v=%b %h want v=0 80", valid, instruction);
    end
  endtask

  task automatic test_stall_full();
    logic [7:0] exp [5];
    exp[0] = 8'h01; exp[1] = 8'h10; exp[2] = 8'h11; exp[3] = 8'h12; exp[4] = 8'h13;
    drain();
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
      checks++;
      if (count !== CW'(i + 1)) begin errors++; $display("FAIL stall_fill%0d: count got %0d want %0d", i, count, i + 1); end
    end
    drive(1'b1, 8'h14, 1'b1, 1'b0);
    checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL stall_full_ready: got %b want 0", rdy_seen); end
    checks++; if (count !== CW'(4) || instruction !== 8'h01) begin
      errors++; $display("FAIL stall_hold: got count=%0d %h want 4 01", count, instruction); end
    // release stall; in_ready still low in the cycle of the first pop
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL stall_pop_ready: got %b want 0", rdy_seen); end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (valid !== 1'b1 || instruction !== exp[i]) begin
        errors++; $display("FAIL stall_out%0d: got v=%b %h want v=1 %h", i, valid, instruction, exp[i]);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      if (i == 1) begin
        checks++; if (rdy_seen !== 1'b1) begin errors++; $display("FAIL stall_ready_back: got %b want 1", rdy_seen); end
      end
    end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stall_no_extra: valid got %b want 0 (%h)", valid, instruction); end
  endtask

  task automatic test_stream();
    drain();
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      if (i >= 1) begin
        checks++;
        if (valid !== 1'b1 || instruction !== 8'(i - 1)) begin
          errors++; $display("FAIL stream_%0d: got v=%b %h want v=1 %h", i - 1, valid, instruction, 8'(i - 1));
        end
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (valid !== 1'b1 || instruction !== 8'hFF) begin
      errors++; $display("FAIL stream_last: got v=%b %h want v=1 ff", valid, instruction);
    end
  endtask

  task automatic test_flush();
    drain();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
    checks++; if (count !== CW'(3)) begin errors++; $display("FAIL flush_pre_count: got %0d want 3", count); end
    drive(1'b1, 8'hAA, 1'b1, 1'b1);
    checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", rdy_seen); end
    checks++; if (valid !== 1'b0 || count !== '0) begin
      errors++; $display("FAIL flush_clear: got v=%b count=%0d want v=0 count=0", valid, count); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL flush_leak%0d: got v=1 %h want v=0", i, instruction); end
    end
  endtask

  task automatic test_async_reset();
    drain();
    drive(1'b1, 8'hA1, 1'b1, 1'b0);
    drive(1'b1, 8'hA2, 1'b1, 1'b0);
    drive(1'b1, 8'hA3, 1'b1, 1'b0);
    checks++; if (count !== CW'(2) || valid !== 1'b1) begin
      errors++; $display("FAIL areset_pre: got count=%0d v=%b want 2 1", count, valid); end
    in_valid = 1'b0; stall = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (valid !== 1'b0 || instruction !== 8'h00 || count !== '0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL areset_now: got v=%b %h count=%0d rdy=%b want 0 00 0 0", valid, instruction, count, in_ready); end
    @(posedge clock); #1;
    reset = 1'b1;
    mq.delete(); mvalid = 1'b0; minstr = 8'h00;
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (valid !== 1'b1 || instruction !== 8'h55) begin
      errors++; $display("FAIL areset_first: got v=%b %h want v=1 55", valid, instruction); end
  endtask

  task automatic test_random();
    int bad;
    drain();
    acc.delete(); dlog.delete();
    for (int c = 0; c < 1200; c++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0, 1'b0);
      checks++;
      if (rdy_seen !== mready || valid !== mvalid || instruction !== minstr || count !== CW'(mq.size())) begin
        errors++;
        $display("FAIL rand_c%0d: got rdy=%b v=%b %h cnt=%0d want rdy=%b v=%b %h cnt=%0d",
                 c, rdy_seen, valid, instruction, count, mready, mvalid, minstr, mq.size());
      end
    end
    drain();
    checks++;
    if (dlog.size() != acc.size()) begin
      errors++; $display("FAIL rand_total: got %0d outputs want %0d", dlog.size(), acc.size());
    end else begin
      bad = -1;
      for (int i = 0; i < acc.size(); i++) if (bad < 0 && dlog[i] !== acc[i]) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++; $display("FAIL rand_order: at %0d got %h want %h", bad, dlog[bad], acc[bad]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_full();
    test_stream();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
